// File: rtl/truth_table_sweep_checker_if.sv
// Harness-side bundle between the sweep checker and the gate under test;
// master = harness/gate side, slave = checker side.
interface truth_table_sweep_checker_if #(
   parameter int N_IN = 4
);
   logic                 start;
   logic                 abort;
   logic [2**N_IN-1:0]   tt_expected;
   logic                 dut_out;
   logic [N_IN-1:0]      stim;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        mismatch_count;
   logic [N_IN-1:0]      first_fail;

   modport master (
      output start, abort, tt_expected, dut_out,
      input  stim, busy, done, pass, mismatch_count, first_fail
   );

   modport slave (
      input  start, abort, tt_expected, dut_out,
      output stim, busy, done, pass, mismatch_count, first_fail
   );
endinterface

// File: rtl/truth_table_sweep_checker.sv
// Exhaustive truth-table sweep of an N_IN-input gate: each vector is held SETTLE cycles then compared;
// a full sweep takes 2^N_IN*(SETTLE+1) cycles after start, all outputs registered, abort returns to IDLE at once.
module truth_table_sweep_checker #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input logic                       clk,
   input logic                       rst,
   truth_table_sweep_checker_if.slave sweep_io
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_COMPARE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_IN-1:0]     stim_q, stim_d;
   logic [2**N_IN-1:0]  tt_q, tt_d;
   logic [N_IN:0]       mm_q, mm_d;
   logic [N_IN-1:0]     ff_q, ff_d;
   logic                pass_q, pass_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                accept;
   logic                last_cnt;
   logic                last_vec;
   logic                mismatch;

   assign accept   = sweep_io.start && !sweep_io.abort;
   assign last_cnt = (cnt_q == CW'(SETTLE - 1));
   assign last_vec = (stim_q == {N_IN{1'b1}});
   assign mismatch = (sweep_io.dut_out != tt_q[stim_q]);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (sweep_io.abort)  state_d = S_IDLE;
            else if (last_cnt)   state_d = S_COMPARE;
         end
         S_COMPARE: begin
            if (sweep_io.abort)  state_d = S_IDLE;
            else if (last_vec)   state_d = S_DONE;
            else                 state_d = S_SETTLE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath / output next values; an aborted compare never touches the results
   always_comb begin
      cnt_d  = cnt_q;
      stim_d = stim_q;
      tt_d   = tt_q;
      mm_d   = mm_q;
      ff_d   = ff_q;
      pass_d = pass_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               tt_d   = sweep_io.tt_expected;
               stim_d = '0;
               cnt_d  = '0;
               mm_d   = '0;
               ff_d   = '0;
               pass_d = 1'b0;
               busy_d = 1'b1;
            end
         end
         S_SETTLE: begin
            if (sweep_io.abort) begin
               stim_d = '0;
               cnt_d  = '0;
               pass_d = 1'b0;
               busy_d = 1'b0;
            end else if (last_cnt) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_COMPARE: begin
            cnt_d = '0;
            if (sweep_io.abort) begin
               stim_d = '0;
               pass_d = 1'b0;
               busy_d = 1'b0;
            end else begin
               if (mismatch) begin
                  mm_d = mm_q + (N_IN+1)'(1);
                  if (mm_q == '0) ff_d = stim_q;
               end
               if (last_vec) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
                  pass_d = (mm_d == '0);
               end else begin
                  stim_d = stim_q + N_IN'(1);
               end
            end
         end
         S_DONE: begin
            stim_d = '0;
         end
         default: begin
            stim_d = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         stim_q <= '0;
         tt_q   <= '0;
         mm_q   <= '0;
         ff_q   <= '0;
         pass_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         stim_q <= stim_d;
         tt_q   <= tt_d;
         mm_q   <= mm_d;
         ff_q   <= ff_d;
         pass_q <= pass_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign sweep_io.stim           = stim_q;
   assign sweep_io.busy           = busy_q;
   assign sweep_io.done           = done_q;
   assign sweep_io.pass           = pass_q;
   assign sweep_io.mismatch_count = mm_q;
   assign sweep_io.first_fail     = ff_q;

endmodule
